jkff_driver: RTL and testbench
==============================

// Module: jkff_driver
// PURPOSE
//  Stimulus/checker master for one JK master-slave flip-flop section with active-low preset/clear.
//  Turns single-cycle commands (hold/reset/set/toggle/preset/clear) into a timed pin sequence on
//  J, K, CLK, PRE_n and CLR_n. Samples Q/Q_ after a settle window and checks them against an
//  internal shadow of the expected state. Sits in benches and board-level harnesses in front of
//  the JK FF models.
// PARAMETERS
//  SETUP_CYC   2  cycles J/K are stable with ff_clk low before the rising edge (>=1)
//  HIGH_CYC    2  cycles ff_clk is high; also the width of preset/clear pulses (>=1)
//  SETTLE_CYC  4  cycles after the falling edge or pulse release before Q/Q_ are sampled (>=1)
// PORTS
//  clk        in   1  system clock; all state changes on posedge
//  clr        in   1  synchronous reset, active-high
//  cmd_valid  in   1  command offered
//  cmd_ready  out  1  driver idle; a command is accepted when cmd_valid && cmd_ready
//  cmd_op     in   3  0 HOLD, 1 RESET(J0K1), 2 SET(J1K0), 3 TOGGLE, 4 PRESET, 5 CLEAR, 6/7 illegal
//  ff_j       out  1  J pin
//  ff_k       out  1  K pin
//  ff_clk     out  1  FF clock pin
//  ff_pre_n   out  1  preset pin, active-low
//  ff_clr_n   out  1  clear pin, active-low
//  ff_q       in   1  Q from DUT
//  ff_q_n     in   1  Q_ from DUT
//  rsp_valid  out  1  one-cycle pulse when a command completes
//  rsp_ok     out  1  check result; valid with rsp_valid
//  rsp_q      out  1  sampled Q; valid with rsp_valid
//  err_cnt    out  8  failed-check count, saturates at 255
// BEHAVIOUR
//  Reset (clr=1 at posedge):
//   - state IDLE; cmd_ready=1; ff_j=ff_k=0; ff_clk=0; ff_pre_n=ff_clr_n=1.
//   - rsp_valid=rsp_ok=rsp_q=0; err_cnt=0; exp_q=0; exp_known=0.
//   - Reset mid-command aborts it with no response and returns the pins to idle levels.
//  States:
//   - IDLE: accept a command.
//   - SETUP: drive ff_j/ff_k for the op; ff_clk=0; lasts SETUP_CYC cycles.
//   - HIGH: ff_clk=1; lasts HIGH_CYC cycles.
//   - PULSE: ff_pre_n or ff_clr_n = 0; lasts HIGH_CYC cycles.
//   - SETTLE: all strobes inactive, ff_clk=0; lasts SETTLE_CYC cycles.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
//  Transitions:
//   - Clocked ops (0-3): IDLE->SETUP->HIGH->SETTLE->RESP.
//   - Ops 4/5: IDLE->PULSE->SETTLE->RESP.
//   - Illegal ops 6/7: IDLE->RESP with rsp_ok=0.
//  cmd_ready=1 only in IDLE. RESP->IDLE, so a new command is accepted the cycle after rsp_valid.
//  ff_j/ff_k keep the op values through HIGH and return to 0 in SETTLE.
//  Latency from the accept edge to the rsp_valid cycle:
//   - clocked ops: SETUP_CYC+HIGH_CYC+SETTLE_CYC+1 (9 at defaults)
//   - ops 4/5: HIGH_CYC+SETTLE_CYC+1 (7)
//   - ops 6/7: 1
//  Sampling: ff_q/ff_q_n are registered at the posedge that ends the last SETTLE cycle.
//  Check: rsp_ok = (q_n == ~q) && (!exp_known || q == exp_next).
//   - exp_next: HOLD exp_q; RESET 0; SET 1; TOGGLE ~exp_q; PRESET 1; CLEAR 0.
//   - After an op with exp_known=0, exp_q <= sampled q. Otherwise exp_q <= exp_next.
//   - Ops 1, 2, 4 and 5 set exp_known=1.
//  err_cnt increments in the RESP cycle when rsp_ok=0. It holds at 255.
//  If cmd_valid is asserted outside IDLE, it is ignored and produces no error.
// STRUCTURE
//  Package jkff_drv_pkg: op-code localparams, state encoding, pin idle-level constants.
//  Sub-module jkff_drv_timer: loadable down-counter with a done flag, reloaded on each phase
//  entry with SETUP_CYC, HIGH_CYC or SETTLE_CYC.
// TESTING
//  1. clr then SET: ff_j=1, ff_k=0; ff_clk rises 2 cycles after accept; rsp_valid at +9,
//     rsp_ok=1, rsp_q=1.
//  2. SET, then TOGGLE x3 against a correct FF model: rsp_q sequence 0,1,0; all rsp_ok=1;
//     err_cnt=0.
//  3. CLEAR: ff_clr_n=0 for exactly 2 cycles, ff_clk stays 0; rsp_valid at +7, rsp_q=0, rsp_ok=1.
//  4. Tie ff_q_n=ff_q, issue SET: rsp_ok=0, err_cnt=1. With 256 failures, err_cnt stays 255.
//  5. cmd_op=7: rsp_valid on the next cycle, rsp_ok=0, and no pin moves. Holding cmd_valid high
//     during an op accepts nothing until after RESP.
//  6. Assert clr during HIGH of TOGGLE: next cycle ff_clk=0, pins idle, no rsp_valid,
//     exp_known=0. The following HOLD returns rsp_ok=1 for either Q level.

Source files
------------

// File: rtl/jkff_drv_pkg.sv
// Shared encodings for the JK flip-flop stimulus/checker driver.
// Covers op codes, FSM state codes, idle pin levels and op decode helpers.
package jkff_drv_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_RESET  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_PRESET = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_HIGH   = 3'd2;
    localparam logic [2:0] ST_PULSE  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    localparam logic PIN_J_IDLE     = 1'b0;
    localparam logic PIN_K_IDLE     = 1'b0;
    localparam logic PIN_CLK_IDLE   = 1'b0;
    localparam logic PIN_PRE_N_IDLE = 1'b1;
    localparam logic PIN_CLR_N_IDLE = 1'b1;

    localparam int TMR_W = 8;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_CLEAR;
    endfunction

    function automatic logic op_is_clocked(input logic [2:0] op);
        return op <= OP_TOGGLE;
    endfunction

    // Ops that force a known level: the FF state is defined afterwards.
    function automatic logic op_sets_known(input logic [2:0] op);
        return (op == OP_RESET) || (op == OP_SET) || (op == OP_PRESET) || (op == OP_CLEAR);
    endfunction

    function automatic logic [1:0] op_jk(input logic [2:0] op);
        logic [1:0] jk;
        case (op)
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jkff_drv_timer.sv
// Phase timer: loadable down-counter, done when the count reaches zero.
// Loading N gives a phase that lasts exactly N cycles.
module jkff_drv_timer
    import jkff_drv_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - {{(W-1){1'b0}}, 1'b1};
        end else if (cnt != '0) begin
            cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/jkff_driver.sv
// Drives one JK master-slave FF section through a timed pin sequence per command
// and checks the sampled Q/Q_ against a shadow of the expected state.
//
// state  | meaning
// IDLE   | pins idle, cmd_ready=1, accept a command
// SETUP  | J/K driven for the op, ff_clk low
// HIGH   | ff_clk high, J/K still driven
// PULSE  | preset or clear strobe low
// SETTLE | all strobes inactive, waiting for Q to settle
// RESP   | rsp_valid for one cycle
module jkff_driver
    import jkff_drv_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int HIGH_CYC   = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    output logic       ff_j,
    output logic       ff_k,
    output logic       ff_clk,
    output logic       ff_pre_n,
    output logic       ff_clr_n,
    input  logic       ff_q,
    input  logic       ff_q_n,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic       rsp_q,
    output logic [7:0] err_cnt
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       op;
    logic [2:0]       op_nxt;
    logic             accept;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             exp_q;
    logic             exp_known;
    logic             exp_next;
    logic             chk_ok;
    logic             drive_jk;
    logic [1:0]       jk;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // Illegal ops jump straight to RESP, so the op is taken from the port that cycle.
    assign op_nxt    = accept ? cmd_op : op;

    jkff_drv_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!op_is_legal(cmd_op)) begin
                        state_nxt = ST_RESP;
                    end else if (op_is_clocked(cmd_op)) begin
                        state_nxt = ST_SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(SETUP_CYC);
                    end else begin
                        state_nxt = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(HIGH_CYC);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_nxt = ST_HIGH;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(HIGH_CYC);
                end
            end
            ST_HIGH, ST_PULSE: begin
                if (tmr_done) begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(SETTLE_CYC);
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        case (op_nxt)
            OP_HOLD:   exp_next = exp_q;
            OP_RESET:  exp_next = 1'b0;
            OP_SET:    exp_next = 1'b1;
            OP_TOGGLE: exp_next = ~exp_q;
            OP_PRESET: exp_next = 1'b1;
            default:   exp_next = 1'b0;
        endcase
    end

    assign chk_ok   = op_is_legal(op_nxt) && (ff_q_n == ~ff_q) && (!exp_known || (ff_q == exp_next));
    assign drive_jk = (state_nxt == ST_SETUP) || (state_nxt == ST_HIGH);
    assign jk       = op_jk(op_nxt);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            op        <= OP_HOLD;
            ff_j      <= PIN_J_IDLE;
            ff_k      <= PIN_K_IDLE;
            ff_clk    <= PIN_CLK_IDLE;
            ff_pre_n  <= PIN_PRE_N_IDLE;
            ff_clr_n  <= PIN_CLR_N_IDLE;
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
            rsp_q     <= 1'b0;
            err_cnt   <= 8'd0;
            exp_q     <= 1'b0;
            exp_known <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            ff_j      <= drive_jk ? jk[1] : PIN_J_IDLE;
            ff_k      <= drive_jk ? jk[0] : PIN_K_IDLE;
            ff_clk    <= (state_nxt == ST_HIGH);
            ff_pre_n  <= !((state_nxt == ST_PULSE) && (op_nxt == OP_PRESET));
            ff_clr_n  <= !((state_nxt == ST_PULSE) && (op_nxt == OP_CLEAR));
            rsp_valid <= (state_nxt == ST_RESP);
            if (state_nxt == ST_RESP) begin
                rsp_q  <= ff_q;
                rsp_ok <= chk_ok;
                if (op_is_legal(op_nxt)) begin
                    exp_q     <= exp_known ? exp_next : ff_q;
                    exp_known <= exp_known || op_sets_known(op_nxt);
                end
            end
            if ((state == ST_RESP) && !rsp_ok && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_jkff_driver.sv
// Bench for jkff_driver: a behavioural JK FF on the pins plus a command-level
// reference model of the expected responses, latencies and error count.
module tb_jkff_driver;

    localparam int SETUP_CYC  = 2;
    localparam int HIGH_CYC   = 2;
    localparam int SETTLE_CYC = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_ready, ff_j, ff_k, ff_clk, ff_pre_n, ff_clr_n;
    logic       ff_q, ff_q_n, rsp_valid, rsp_ok, rsp_q;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;

    // FF model and fault knobs
    logic mq = 1'b0;
    logic freeze = 1'b0;
    logic tie_bad = 1'b0;

    // reference model of the driver's shadow state
    bit m_known = 1'b0;
    bit m_exp = 1'b0;
    int m_err = 0;

    // observations from the last command
    int r_lat, r_clk_rise, r_clk_hi, r_pre_lo, r_clr_lo, r_ready_hi;
    bit r_ok, r_q, r_moved, r_j1, r_k1;

    jkff_driver #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .ff_j     (ff_j),
        .ff_k     (ff_k),
        .ff_clk   (ff_clk),
        .ff_pre_n (ff_pre_n),
        .ff_clr_n (ff_clr_n),
        .ff_q     (ff_q),
        .ff_q_n   (ff_q_n),
        .rsp_valid(rsp_valid),
        .rsp_ok   (rsp_ok),
        .rsp_q    (rsp_q),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge ff_clk or negedge ff_pre_n or negedge ff_clr_n) begin
        if (!freeze) begin
            if (!ff_pre_n) mq <= 1'b1;
            else if (!ff_clr_n) mq <= 1'b0;
            else begin
                case ({ff_j, ff_k})
                    2'b01:   mq <= 1'b0;
                    2'b10:   mq <= 1'b1;
                    2'b11:   mq <= ~mq;
                    default: mq <= mq;
                endcase
            end
        end
    end

    assign ff_q   = mq;
    assign ff_q_n = tie_bad ? mq : ~mq;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        m_known = 1'b0;
        m_exp = 1'b0;
        m_err = 0;
    endtask

    // Issue one command from IDLE; returns at the IDLE sample after the response.
    task automatic do_cmd(input logic [2:0] op, input bit hold_valid);
        cmd_op = op;
        cmd_valid = 1'b1;
        step();
        if (!hold_valid) cmd_valid = 1'b0;
        r_lat = 0; r_clk_rise = 0; r_clk_hi = 0; r_pre_lo = 0; r_clr_lo = 0;
        r_ready_hi = 0; r_moved = 1'b0; r_ok = 1'b0; r_q = 1'b0;
        r_j1 = ff_j; r_k1 = ff_k;
        for (int n = 1; n <= 20; n++) begin
            if (ff_clk && r_clk_rise == 0) r_clk_rise = n;
            if (ff_clk) r_clk_hi++;
            if (!ff_pre_n) r_pre_lo++;
            if (!ff_clr_n) r_clr_lo++;
            if (ff_j || ff_k || ff_clk || !ff_pre_n || !ff_clr_n) r_moved = 1'b1;
            if (cmd_ready) r_ready_hi++;
            if (rsp_valid) begin
                r_lat = n;
                r_ok = rsp_ok;
                r_q = rsp_q;
                break;
            end
            step();
        end
        step();
        if (hold_valid) begin
            check("ready_after_resp", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
        end
    endtask

    // Expected outcome from the command rules, compared with what was observed.
    task automatic model_check(input logic [2:0] op);
        bit legal, nxt, eok, q_now, qn_now;
        int elat;
        legal = (op <= 3'd5);
        q_now = mq;
        qn_now = tie_bad ? mq : ~mq;
        case (op)
            3'd0:    nxt = m_exp;
            3'd1:    nxt = 1'b0;
            3'd2:    nxt = 1'b1;
            3'd3:    nxt = ~m_exp;
            3'd4:    nxt = 1'b1;
            default: nxt = 1'b0;
        endcase
        eok = legal && (qn_now != q_now) && (!m_known || q_now == nxt);
        if (!legal) elat = 1;
        else if (op >= 3'd4) elat = HIGH_CYC + SETTLE_CYC + 1;
        else elat = SETUP_CYC + HIGH_CYC + SETTLE_CYC + 1;
        check("latency", r_lat, elat);
        check("rsp_ok", {31'd0, r_ok}, {31'd0, eok});
        if (legal) begin
            check("rsp_q", {31'd0, r_q}, {31'd0, q_now});
            m_exp = m_known ? nxt : q_now;
            if (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) m_known = 1'b1;
        end
        if (!eok && m_err < 255) m_err++;
        check("err_cnt", {24'd0, err_cnt}, m_err);
    endtask

    initial begin
        // reset state
        step();
        step();
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_pins", {27'd0, ff_j, ff_k, ff_clk, ff_pre_n, ff_clr_n}, 32'b00011);
        check("rst_rsp", {29'd0, rsp_valid, rsp_ok, rsp_q}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        clr = 1'b0;

        // SET after reset
        do_cmd(3'd2, 1'b0);
        check("set_j", {31'd0, r_j1}, 32'd1);
        check("set_k", {31'd0, r_k1}, 32'd0);
        check("set_clk_rise", r_clk_rise, SETUP_CYC + 1);
        check("set_clk_hi", r_clk_hi, HIGH_CYC);
        check("set_q_val", {31'd0, r_q}, 32'd1);
        model_check(3'd2);

        // toggles: Q goes 0,1,0
        for (int i = 0; i < 3; i++) begin
            do_cmd(3'd3, 1'b0);
            check("toggle_q_seq", {31'd0, r_q}, (i % 2 == 0) ? 32'd0 : 32'd1);
            model_check(3'd3);
        end
        check("toggle_err", {24'd0, err_cnt}, 32'd0);

        // CLEAR pulse
        do_cmd(3'd5, 1'b0);
        check("clear_low_cycles", r_clr_lo, HIGH_CYC);
        check("clear_no_clk", r_clk_rise, 32'd0);
        check("clear_no_pre", r_pre_lo, 32'd0);
        model_check(3'd5);

        // PRESET pulse
        do_cmd(3'd4, 1'b0);
        check("preset_low_cycles", r_pre_lo, HIGH_CYC);
        model_check(3'd4);

        // illegal op: immediate response, no pin activity
        do_cmd(3'd7, 1'b0);
        check("illegal_moved", {31'd0, r_moved}, 32'd0);
        model_check(3'd7);

        // cmd_valid held through an op
        do_cmd(3'd0, 1'b1);
        check("held_ready_busy", r_ready_hi, 32'd0);
        model_check(3'd0);
        step();
        check("held_no_extra_rsp", {31'd0, rsp_valid}, 32'd0);

        // Q_ tied to Q, then saturation
        do_reset();
        tie_bad = 1'b1;
        do_cmd(3'd2, 1'b0);
        model_check(3'd2);
        check("tie_err_one", {24'd0, err_cnt}, 32'd1);
        tie_bad = 1'b0;
        for (int i = 0; i < 256; i++) begin
            do_cmd(3'd6, 1'b0);
            model_check(3'd6);
        end
        check("err_saturated", {24'd0, err_cnt}, 32'd255);

        // reset during HIGH of TOGGLE, twice so HOLD sees both Q levels
        for (int i = 0; i < 2; i++) begin
            cmd_op = 3'd3;
            cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            step();
            step();
            check("abort_in_high", {31'd0, ff_clk}, 32'd1);
            clr = 1'b1;
            step();
            clr = 1'b0;
            m_known = 1'b0; m_exp = 1'b0; m_err = 0;
            check("abort_pins", {27'd0, ff_j, ff_k, ff_clk, ff_pre_n, ff_clr_n}, 32'b00011);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            for (int n = 0; n < 10; n++) begin
                step();
                if (rsp_valid) check("abort_late_rsp", 32'd1, 32'd0);
            end
            do_cmd(3'd0, 1'b0);
            check("abort_hold_ok", {31'd0, r_ok}, 32'd1);
            model_check(3'd0);
        end

        // randomized commands with occasional FF faults
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            freeze = ($urandom_range(0, 5) == 0);
            tie_bad = ($urandom_range(0, 9) == 0);
            do_cmd(op, 1'b0);
            model_check(op);
            freeze = 1'b0;
            tie_bad = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
